// File: rtl/tb_uart_pkg.sv
// Shared 8N1 receiver types and constants: FSM state enum, frame shape, baud divider helper.
package tb_uart_pkg;

   localparam int unsigned DataBits = 8;
   localparam int unsigned StopBits = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_rx_state_e;

   // Clock cycles per bit, truncated.
   function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with optional fall-through.
// Latency: 1 cycle push-to-visible (0 with FALL_THROUGH).
// Backpressure: push while full is dropped; pop while empty is ignored.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DEPTH        = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]       cnt_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  bypass, do_push, do_pop;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   // In fall-through mode a push and pop on an empty FIFO pass straight through.
   assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
   assign do_push = push_i && !full_o && !bypass;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = (FALL_THROUGH && empty_o && push_i) ? data_i : mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         if (do_push && !do_pop) cnt_q <= cnt_q + CntW'(1);
         else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
      end
   end

endmodule

// File: rtl/sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Latency: STAGES cycles.
// Backpressure: none, free-running.
module sync #(
   parameter int unsigned STAGES      = 2,
   parameter bit          RESET_VALUE = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic serial_i,
   output logic serial_o
);

   logic [STAGES-1:0] reg_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reg_q <= {STAGES{RESET_VALUE}};
      end else begin
         reg_q <= {reg_q[STAGES-2:0], serial_i};
      end
   end

   assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/tb_uart_rx.sv
// Oversampling 8N1 UART receiver with byte FIFO, framing-error and overflow pulses.
// Latency: valid_o rises 3 + Div/2 + 9*Div cycles after the line's falling edge.
// Backpressure: valid/ready on the FIFO head; bytes decoded while the FIFO is full are dropped.
module tb_uart_rx
   import tb_uart_pkg::*;
#(
   parameter int unsigned ClkFreq   = 500_000,
   parameter int unsigned Baud      = 115_200,
   parameter int unsigned FifoDepth = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overflow_o,
   output logic       busy_o
);

   localparam int unsigned     Div     = calc_div(ClkFreq, Baud);
   localparam int unsigned     CntW    = $clog2(Div);
   localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Div - 1);
   localparam logic [2:0]      LastBit = 3'(DataBits - 1);

   if (Div < 4) begin : g_div_check
      $error("tb_uart_rx: ClkFreq/Baud must be at least 4");
   end
   if (FifoDepth < 2) begin : g_depth_check
      $error("tb_uart_rx: FifoDepth must be at least 2");
   end
   if (StopBits != 1) begin : g_stop_check
      $error("tb_uart_rx: only one stop bit is supported");
   end

   uart_rx_state_e  state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            rx_s, rx_prev_q;
   logic            frame_err_q, overflow_q;
   logic            cnt_zero, fall, stop_ok, stop_bad;
   logic            fifo_full, fifo_empty;

   sync #(
      .STAGES      (2),
      .RESET_VALUE (1'b1)
   ) i_sync (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .serial_i (rx_i),
      .serial_o (rx_s)
   );

   assign cnt_zero = (cnt_q == '0);
   assign fall     = rx_prev_q && !rx_s;
   assign stop_ok  = (state_q == ST_STOP) && cnt_zero && rx_s;
   assign stop_bad = (state_q == ST_STOP) && cnt_zero && !rx_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_prev_q   <= 1'b1;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rx_prev_q   <= rx_s;
         frame_err_q <= stop_bad;
         overflow_q  <= stop_ok && fifo_full;
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  cnt_q   <= CntHalf;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (!cnt_zero) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else if (!rx_s) begin
                  cnt_q     <= CntFull;
                  bit_idx_q <= '0;
                  state_q   <= ST_DATA;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (!cnt_zero) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  shift_q   <= {rx_s, shift_q[7:1]};
                  cnt_q     <= CntFull;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == LastBit) state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (!cnt_zero) cnt_q <= cnt_q - CntW'(1);
               else state_q <= rx_s ? ST_IDLE : ST_BREAK;
            end
            // Stay here while the line is held low so a long break is not mistaken for a start bit.
            ST_BREAK: begin
               if (rx_s) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (8),
      .DEPTH        (FifoDepth)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (shift_q),
      .push_i  (stop_ok),
      .data_o  (data_o),
      .pop_i   (ready_i && !fifo_empty)
   );

   assign valid_o     = !fifo_empty;
   assign frame_err_o = frame_err_q;
   assign overflow_o  = overflow_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule
